// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NUM_CH 8-bit channels.
// A channel is queued whenever its input differs from the last captured value.
// Pending channels are served round-robin, with an optional tag byte before
// each data byte. A UART that never accepts a byte gets a one-cycle reset.
module uart_tx_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int TAG_EN      = 1,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NUM_CH-1:0]   ch_data,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  uart_reset,
  output logic                  busy,
  output logic [3:0]            grant_id,
  output logic                  send_led,
  output logic [7:0]            leds
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, START, ACK, DONE, RECOVER} state_t;
  typedef enum logic {PH_TAG, PH_DATA} phase_t;

  state_t        r_state, w_state_next;
  phase_t        r_phase, w_phase_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic [7:0]    r_cur_data, w_cur_data_next;
  logic [3:0]    r_grant_id, w_grant_id_next;
  logic [3:0]    r_rr_ptr, w_rr_ptr_next;
  logic [CW-1:0] r_ack_cnt, w_ack_cnt_next, w_ack_cnt_inc;
  logic          r_send_led, w_send_led_next;
  logic [7:0]    r_leds, w_leds_next;

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_pend_set;
  logic [NUM_CH-1:0] w_pend_clr;
  logic [7:0]        w_snap [NUM_CH];

  logic       w_found;
  logic [3:0] w_pick;
  logic [7:0] w_pick_data;
  int         w_idx;

  // Per-channel change detection, snapshot and pending flag.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] r_last_seen;
      logic [7:0] r_snap;
      logic       r_pending;
      logic       w_change;

      assign w_change = (ch_data[8*gi +: 8] != r_last_seen);

      // A new value always wins over a grant clear in the same cycle, so the
      // newest value is never lost.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_last_seen <= 8'd0;
          r_snap      <= 8'd0;
          r_pending   <= 1'b0;
        end else begin
          if (w_change) begin
            r_last_seen <= ch_data[8*gi +: 8];
            r_snap      <= ch_data[8*gi +: 8];
          end
          if (w_change || w_pend_set[gi]) begin
            r_pending <= 1'b1;
          end else if (w_pend_clr[gi]) begin
            r_pending <= 1'b0;
          end
        end
      end

      assign w_pending[gi] = r_pending;
      assign w_snap[gi]    = r_snap;
    end
  endgenerate

  // Round-robin pick: first pending channel at or after rr_ptr, with wrap.
  always_comb begin
    w_found     = 1'b0;
    w_pick      = 4'd0;
    w_pick_data = 8'd0;
    w_idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CH) begin
        w_idx = w_idx - NUM_CH;
      end
      for (int j = 0; j < NUM_CH; j++) begin
        if (!w_found && (j == w_idx) && w_pending[j]) begin
          w_found = 1'b1;
          w_pick  = 4'(j);
        end
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (4'(j) == w_pick) begin
        w_pick_data = w_snap[j];
      end
    end
  end

  assign w_ack_cnt_inc = r_ack_cnt + CW'(1);

  // Next-state and datapath updates for the transmit sequencer.
  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_tx_data_next  = r_tx_data;
    w_cur_data_next = r_cur_data;
    w_grant_id_next = r_grant_id;
    w_rr_ptr_next   = r_rr_ptr;
    w_ack_cnt_next  = r_ack_cnt;
    w_send_led_next = r_send_led;
    w_leds_next     = r_leds;
    w_pend_set      = '0;
    w_pend_clr      = '0;

    case (r_state)
      IDLE: begin
        if (w_found && tx_ready) begin
          w_cur_data_next = w_pick_data;
          w_grant_id_next = w_pick;
          for (int j = 0; j < NUM_CH; j++) begin
            w_pend_clr[j] = (4'(j) == w_pick);
          end
          w_rr_ptr_next = (w_pick == 4'(NUM_CH - 1)) ? 4'd0 : w_pick + 4'd1;
          if (TAG_EN != 0) begin
            w_tx_data_next = {4'hA, w_pick};
            w_phase_next   = PH_TAG;
          end else begin
            w_tx_data_next = w_pick_data;
            w_phase_next   = PH_DATA;
          end
          w_state_next = START;
        end
      end
      START: begin
        w_ack_cnt_next = '0;
        w_state_next   = ACK;
      end
      ACK: begin
        if (!tx_ready) begin
          w_state_next = DONE;
        end else if (w_ack_cnt_inc == CW'(ACK_TIMEOUT - 1)) begin
          w_state_next = RECOVER;
        end else begin
          w_ack_cnt_next = w_ack_cnt_inc;
        end
      end
      DONE: begin
        if (tx_ready) begin
          if (r_phase == PH_TAG) begin
            w_tx_data_next = r_cur_data;
            w_phase_next   = PH_DATA;
            w_state_next   = START;
          end else begin
            w_leds_next     = r_cur_data;
            w_send_led_next = ~r_send_led;
            w_state_next    = IDLE;
          end
        end
      end
      RECOVER: begin
        // Requeue the abandoned channel and make it the first candidate.
        for (int j = 0; j < NUM_CH; j++) begin
          w_pend_set[j] = (4'(j) == r_grant_id);
        end
        w_rr_ptr_next = r_grant_id;
        w_state_next  = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= PH_DATA;
      r_tx_data  <= 8'd0;
      r_cur_data <= 8'd0;
      r_grant_id <= 4'd0;
      r_rr_ptr   <= 4'd0;
      r_ack_cnt  <= '0;
      r_send_led <= 1'b0;
      r_leds     <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_tx_data  <= w_tx_data_next;
      r_cur_data <= w_cur_data_next;
      r_grant_id <= w_grant_id_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_ack_cnt  <= w_ack_cnt_next;
      r_send_led <= w_send_led_next;
      r_leds     <= w_leds_next;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = (r_state == START);
  assign uart_reset = (r_state == RECOVER);
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_grant_id;
  assign send_led   = r_send_led;
  assign leds       = r_leds;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a small UART model answers tx_start pulses,
// and every byte the DUT starts is compared against a queue of expected bytes.
module tb_uart_tx_scheduler;

  localparam int NUM_CH      = 4;
  localparam int TAG_EN      = 1;
  localparam int ACK_TIMEOUT = 16;

  logic                clk;
  logic                rst;
  logic [8*NUM_CH-1:0] ch_data;
  logic                tx_ready;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                uart_reset;
  logic                busy;
  logic [3:0]          grant_id;
  logic                send_led;
  logic [7:0]          leds;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         last_start_cyc = 0;
  logic       prev_start = 1'b0;
  logic       uart_ignore = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_scheduler #(
    .NUM_CH      (NUM_CH),
    .TAG_EN      (TAG_EN),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_data    (ch_data),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .uart_reset (uart_reset),
    .busy       (busy),
    .grant_id   (grant_id),
    .send_led   (send_led),
    .leds       (leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] v);
    ch_data[8*ch +: 8] = v;
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back(a);
    exp_q.push_back(b);
  endtask

  // Wait until every expected byte has been started and the DUT is idle again.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(busy == 1'b0 && exp_q.size() == 0 && tx_ready == 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // UART model: accepts two cycles after tx_start, then busy for ten cycles.
  initial begin : uart_model
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && !uart_ignore && !rst) begin
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        repeat (10) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard: each tx_start pops one expected byte.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        chk("tx_start_single_cycle", 32'(prev_start), 32'd0);
        chk("tx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("tx byte %02h (expected %02h) grant %0d cycle %0d", tx_data, e, grant_id, cyc);
          chk("tx_byte", 32'(tx_data), 32'(e));
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s0;
    int n;

    rst         = 1'b1;
    ch_data     = '0;
    uart_ignore = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_uart_reset", 32'(uart_reset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_send_led", 32'(send_led), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single channel, tag then data.
    s0 = start_cnt;
    push2(8'hA0, 8'h55);
    set_ch(0, 8'h55);
    wait_done("t1", 2000);
    chk("t1_leds", 32'(leds), 32'h55);
    chk("t1_send_led", 32'(send_led), 32'd1);
    chk("t1_start_pulses", 32'(start_cnt - s0), 32'd2);

    // Fresh reset, then all four channels change together.
    rst     = 1'b1;
    ch_data = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t2_leds_after_rst", 32'(leds), 32'd0);
    s0 = start_cnt;
    push2(8'hA0, 8'h11);
    push2(8'hA1, 8'h22);
    push2(8'hA2, 8'h33);
    push2(8'hA3, 8'h44);
    ch_data = {8'h44, 8'h33, 8'h22, 8'h11};
    wait_done("t2a", 4000);
    chk("t2a_grant", 32'(grant_id), 32'd3);
    chk("t2a_leds", 32'(leds), 32'h44);
    chk("t2a_send_led", 32'(send_led), 32'd0);
    chk("t2a_start_pulses", 32'(start_cnt - s0), 32'd8);

    // ch1 and ch3 again: pointer wrapped to 0, so ch1 first.
    push2(8'hA1, 8'h2F);
    push2(8'hA3, 8'h4F);
    set_ch(3, 8'h4F);
    set_ch(1, 8'h2F);
    wait_done("t2b", 2000);
    chk("t2b_grant", 32'(grant_id), 32'd3);
    chk("t2b_leds", 32'(leds), 32'h4F);

    // ch2 changes twice while ch0 is transmitting: only the latest is sent.
    s0 = start_cnt;
    push2(8'hA0, 8'h77);
    set_ch(0, 8'h77);
    repeat (4) @(negedge clk);
    chk("t3_busy", 32'(busy), 32'd1);
    set_ch(2, 8'h10);
    @(negedge clk);
    set_ch(2, 8'h20);
    push2(8'hA2, 8'h20);
    wait_done("t3", 2000);
    chk("t3_leds", 32'(leds), 32'h20);
    chk("t3_grant", 32'(grant_id), 32'd2);
    chk("t3_start_pulses", 32'(start_cnt - s0), 32'd4);

    // UART ignores the start: timeout, recovery, same channel retried first.
    uart_ignore = 1'b1;
    exp_q.push_back(8'hA1);
    push2(8'hA1, 8'h5A);
    set_ch(1, 8'h5A);
    repeat (4) @(negedge clk);
    push2(8'hA3, 8'h3C);
    set_ch(3, 8'h3C);
    n = 0;
    while (!uart_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_uart_reset_seen", 32'(uart_reset), 32'd1);
    chk("t4_timeout_distance", 32'(cyc - last_start_cyc), 32'd16);
    chk("t4_grant", 32'(grant_id), 32'd1);
    uart_ignore = 1'b0;
    @(negedge clk);
    chk("t4_uart_reset_width", 32'(uart_reset), 32'd0);
    wait_done("t4", 2000);
    chk("t4_leds", 32'(leds), 32'h3C);

    // Change on the granted channel in the grant cycle: 05 then 06.
    push2(8'hA0, 8'h05);
    set_ch(0, 8'h05);
    @(negedge clk);
    push2(8'hA0, 8'h06);
    set_ch(0, 8'h06);
    @(negedge clk);
    chk("t5_started", 32'(tx_start), 32'd1);
    chk("t5_grant", 32'(grant_id), 32'd0);
    wait_done("t5", 2000);
    chk("t5_leds", 32'(leds), 32'h06);

    // Reset while the DUT sits in DONE.
    exp_q.push_back(8'hA2);
    set_ch(2, 8'h99);
    n = 0;
    while (!(exp_q.size() == 0 && tx_ready == 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_tag_accepted", 32'(n < 100), 32'd1);
    repeat (2) @(negedge clk);
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    s0      = start_cnt;
    rst     = 1'b1;
    ch_data = '0;
    @(negedge clk);
    chk("t6_tx_data", 32'(tx_data), 32'd0);
    chk("t6_tx_start", 32'(tx_start), 32'd0);
    chk("t6_uart_reset", 32'(uart_reset), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_grant", 32'(grant_id), 32'd0);
    chk("t6_send_led", 32'(send_led), 32'd0);
    chk("t6_leds", 32'(leds), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_quiet", 32'(start_cnt - s0), 32'd0);
    push2(8'hA1, 8'hC3);
    set_ch(1, 8'hC3);
    wait_done("t6b", 2000);
    chk("t6b_leds", 32'(leds), 32'hC3);
    chk("t6b_send_led", 32'(send_led), 32'd1);
    chk("t6b_grant", 32'(grant_id), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmitter between NUM_CH 8-bit data channels. Each channel's value is sent automatically whenever it changes from the last value captured. Pending channels are served round-robin, with an optional channel-tag byte before each data byte. The block sits between the application's status/data registers and the UART TX core, and recovers a stalled UART with a one-cycle `uart_reset` pulse.

## Interface
Parameters:
- NUM_CH, 4, number of channels (2..16)
- TAG_EN, 1, 1 = send tag byte {4'hA, channel index[3:0]} before each data byte
- ACK_TIMEOUT, 1024, cycles to wait for the UART to accept a byte (tx_ready falling) before recovery

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ch_data  in  8*NUM_CH  channel i value at bits [8i+7:8i]
- tx_ready  in  1  UART idle/ready (1 = can accept byte; drops while transmitting)
- tx_data  out  8  byte to UART, stable from tx_start until tx_ready returns high
- tx_start  out  1  one-cycle request to UART to send tx_data
- uart_reset  out  1  one-cycle reset pulse to UART on ack timeout
- busy  out  1  high in any state other than IDLE
- grant_id  out  4  index of channel currently/last served
- send_led  out  1  toggles on each completed data byte
- leds  out  8  last completed data byte

## Operation
- Per channel: last_seen[i] (reset 0), snap[i], pending[i] (reset 0).
- Each cycle, if ch_data[i] != last_seen[i]:
  - last_seen[i] and snap[i] <= ch_data[i]
  - pending[i] <= 1
  - While already pending, the newest value overwrites snap (latest wins, no queueing).
- FSM states: IDLE, START, ACK, DONE, RECOVER.
- IDLE: if any pending and tx_ready=1:
  - Pick the first pending index searching from rr_ptr upward with wrap (rr_ptr resets to 0).
  - Latch cur_data <= snap[g]; grant_id <= g; clear pending[g]; rr_ptr <= g+1 mod NUM_CH.
  - tx_data <= TAG_EN ? tag : snap[g]; phase <= TAG_EN ? TAG : DATA; go to START.
- START: tx_start=1 for exactly one cycle; clear ack counter; go to ACK.
- ACK: wait for tx_ready=0, then go to DONE.
  - If the counter reaches ACK_TIMEOUT-1 with tx_ready still 1, go to RECOVER.
- DONE: wait for tx_ready=1.
  - If phase=TAG: tx_data <= cur_data; phase <= DATA; go to START.
  - Else: leds <= cur_data; send_led toggles; go to IDLE.
- RECOVER: uart_reset=1 for one cycle; pending[grant_id] <= 1 (snap unchanged or newer); rr_ptr <= grant_id so the same channel is retried first; go to IDLE.
- No timeout in DONE; a UART that never finishes stalls the block until rst.

## Timing
- Reset values: tx_data 0, tx_start 0, uart_reset 0, busy 0, grant_id 0, send_led 0, leds 0, state IDLE, all pending 0, last_seen 0.
- Nonzero ch_data after reset counts as a change and is sent.
- Latency: change sampled at edge E sets pending at E. With the FSM idle and tx_ready=1, grant happens at E+1 and tx_start is high in the cycle after E+1.
- Same-cycle grant clear and new change on the same channel: set wins. pending stays 1 and snap takes the new value; the granted (old) byte is still sent.
- Between bytes of one tag/data pair: at least one cycle in START, so tx_start pulses never merge.
- Per byte: at least 3 cycles (START, ACK, DONE) plus UART busy time.
- Recovery: uart_reset is high the cycle after timeout; the retry tx_start comes no earlier than 2 cycles later.
- rst mid-transfer: all state returns to reset values at that edge. tx_start and uart_reset are 0 from the next cycle; pending snapshots are discarded.
- tx_data is a register, held constant from START through the end of DONE.

## Test plan
- Reset then ch0=8'h55, UART model accepts after 2 cycles and busy 10 cycles, TAG_EN=1 -> tx sequence 8'hA0, 8'h55; leds=8'h55; send_led=1; tx_start exactly 2 single-cycle pulses.
- ch0..ch3 change in the same cycle to 11,22,33,44 -> data order 11,22,33,44 with tags A0..A3. Then ch1 and ch3 change again -> ch1 served before ch3 (rr_ptr wrap from 0).
- ch2 changes 8'h10 then 8'h20 while another channel is transmitting -> ch2 sent once with 8'h20.
- tx_ready held 1 (UART ignores start), ACK_TIMEOUT=16 -> uart_reset high exactly 1 cycle, 16 cycles after tx_start. The same channel is retried first once tx_ready behaves.
- Change on the granted channel in the grant cycle (ch0 5->6 at grant) -> 5 sent, then 6 sent next.
- Assert rst during DONE -> next cycle all outputs 0, busy 0, no further tx_start until a new change.
